// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit adder/subtractor.
// Two requesters issue operations over valid/ready; results return tagged with the requester ID.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_mode;
  logic             op_id;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // Grant is combinational so the winner sees ready in the same cycle as its valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || !prio))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Subtraction is A + ~B + 1; overflow is judged on the effective (inverted) B operand.
  assign b_eff = op_b ^ {WIDTH{op_mode}};
  assign sum   = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_mode};
  assign ovf   = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_mode   <= 1'b0;
      op_id     <= 1'b0;
      res_valid <= 1'b0;
      res_s     <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            op_a    <= req0_a;
            op_b    <= req0_b;
            op_mode <= req0_mode;
            op_id   <= 1'b0;
            state   <= EXEC;
          end else if (grant1) begin
            op_a    <= req1_a;
            op_b    <= req1_b;
            op_mode <= req1_mode;
            op_id   <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_s     <= sum[WIDTH-1:0];
          res_cout  <= sum[WIDTH];
          res_ovf   <= ovf;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            prio      <= ~res_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_addsub_arbiter;

  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;
  localparam int HALF  = 1 << (WIDTH - 1);

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready, req0_mode;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_mode;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             res_valid, res_ready, res_cout, res_ovf, res_id, busy;
  logic [WIDTH-1:0] res_s;

  int tests;
  int failures;

  addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_cout(res_cout),
    .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic using plain integers: unsigned for sum/carry, signed for overflow.
  function automatic void refCalc(input int a, input int b, input int mode,
                                  output int s, output int c, output int o);
    int sa, sb, sr;
    if (mode != 0) begin
      s = (a - b) & (MODV - 1);
      c = (a >= b) ? 1 : 0;
    end else begin
      s = (a + b) & (MODV - 1);
      c = (a + b >= MODV) ? 1 : 0;
    end
    sa = (a >= HALF) ? a - MODV : a;
    sb = (b >= HALF) ? b - MODV : b;
    sr = (mode != 0) ? sa - sb : sa + sb;
    o  = (sr < -HALF || sr > HALF - 1) ? 1 : 0;
  endfunction

  // Transaction-level model: phase 0 free, 1 computing, 2 holding a result.
  int mPhase, mPrio, mE0, mE1;
  int pS, pC, pO, pId;
  int eS, eC, eO, eId;

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("model rst res_valid", res_valid, 0);
      checkOutput("model rst ready0", req0_ready, 0);
      checkOutput("model rst ready1", req1_ready, 0);
      checkOutput("model rst busy", busy, 0);
      checkOutput("model rst res_s", res_s, 0);
      mPhase = 0; mPrio = 0;
      eS = 0; eC = 0; eO = 0; eId = 0;
    end else begin
      mE0 = (mPhase == 0 && req0_valid && (!req1_valid || mPrio == 0)) ? 1 : 0;
      mE1 = (mPhase == 0 && req1_valid && mE0 == 0) ? 1 : 0;
      checkOutput("model ready0", req0_ready, mE0);
      checkOutput("model ready1", req1_ready, mE1);
      checkOutput("model busy", busy, (mPhase != 0) ? 1 : 0);
      checkOutput("model res_valid", res_valid, (mPhase == 2) ? 1 : 0);
      checkOutput("model res_s", res_s, eS);
      checkOutput("model res_cout", res_cout, eC);
      checkOutput("model res_ovf", res_ovf, eO);
      checkOutput("model res_id", res_id, eId);
      case (mPhase)
        0: begin
          if (mE0 == 1) begin
            refCalc(int'(req0_a), int'(req0_b), int'(req0_mode), pS, pC, pO);
            pId = 0; mPhase = 1;
          end else if (mE1 == 1) begin
            refCalc(int'(req1_a), int'(req1_b), int'(req1_mode), pS, pC, pO);
            pId = 1; mPhase = 1;
          end
        end
        1: begin
          eS = pS; eC = pC; eO = pO; eId = pId;
          mPhase = 2;
        end
        default: begin
          if (res_ready) begin
            mPhase = 0;
            mPrio  = 1 - eId;
          end
        end
      endcase
    end
  end

  // Issue one operation from one requester and check the returned result against literals.
  task automatic applyStimulus(input string name, input int id, input int a, input int b, input int mode,
                               input int expS, input int expC, input int expO, input bit scramble);
    int n;
    bit acc;
    bit got;
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = WIDTH'(a); req0_b = WIDTH'(b); req0_mode = mode[0];
    end else begin
      req1_valid = 1'b1; req1_a = WIDTH'(a); req1_b = WIDTH'(b); req1_mode = mode[0];
    end
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) acc = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput({name, " accept"}, int'(acc), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (scramble) begin
      req0_a = ~req0_a; req0_b = ~req0_b; req0_mode = ~req0_mode;
      req1_a = ~req1_a; req1_b = ~req1_b; req1_mode = ~req1_mode;
    end
    n = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (res_valid) got = 1'b1;
    end
    checkOutput({name, " latency"}, n, 2);
    checkOutput({name, " res_s"}, res_s, expS);
    checkOutput({name, " res_cout"}, res_cout, expC);
    checkOutput({name, " res_ovf"}, res_ovf, expO);
    checkOutput({name, " res_id"}, res_id, id);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, cnt0, cnt1;
    bit got;
    tests = 0;
    failures = 0;
    rst = 1'b1;
    res_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_mode = 1'b0;
    #3;
    checkOutput("reset res_valid", res_valid, 0);
    checkOutput("reset res_s", res_s, 0);
    checkOutput("reset busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("add 1+2",   0, 1, 2, 0, 3, 0, 0, 1'b0);
    applyStimulus("sub 5-2",   1, 5, 2, 1, 3, 1, 0, 1'b0);
    applyStimulus("add 15+1",  0, 15, 1, 0, 0, 1, 0, 1'b0);
    applyStimulus("sub 4-6",   1, 4, 6, 1, 14, 0, 0, 1'b0);
    applyStimulus("add 7+1",   0, 7, 1, 0, 8, 0, 1, 1'b0);
    applyStimulus("sub 8-1",   1, 8, 1, 1, 7, 1, 1, 1'b0);
    applyStimulus("isolation", 0, 3, 4, 0, 7, 0, 0, 1'b1);

    // Reset in the middle of an operation drops it.
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_mode = 1'b0;
    @(negedge clk);
    checkOutput("midrst accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checkOutput("midrst busy before", busy, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst res_valid", res_valid, 0);
    checkOutput("midrst res_s", res_s, 0);
    checkOutput("midrst res_id", res_id, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    got = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    checkOutput("midrst no result", int'(got), 0);

    // Continuous dual requests alternate starting with requester 0.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd1; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd3; req1_mode = 1'b1;
    k = 0; cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      cnt0 += int'(req0_ready);
      cnt1 += int'(req1_ready);
      if (res_valid && res_ready) begin
        checkOutput($sformatf("arb id %0d", k), res_id, k % 2);
        k++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("arb results", k, 4);
    checkOutput("arb ready0 pulses", cnt0, 2);
    checkOutput("arb ready1 pulses", cnt1, 2);
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Back-pressure: result must hold while res_ready is low.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("bp result seen", int'(got), 1);
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd6; req1_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bp hold valid", res_valid, 1);
      checkOutput("bp hold res_s", res_s, 5);
      checkOutput("bp hold id", res_id, 0);
      checkOutput("bp ready0", req0_ready, 0);
      checkOutput("bp ready1", req1_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp completion valid", res_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp after valid", res_valid, 0);
    checkOutput("bp next accept ready1", req1_ready, 1);
    checkOutput("bp next accept ready0", req0_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_mode = 1'($urandom);
      req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_mode = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one WIDTH-bit adder/subtractor datapath between two requesters.
- Each requester presents operands and a mode (0 = add, 1 = subtract) over a valid/ready handshake.
- The block grants round-robin, computes one registered result per operation, and returns it on a single result channel tagged with the requester ID.
- It sits between the operand-issuing control logic and the shared arithmetic unit, so callers never instantiate a private adder/subtractor.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_mode  in  1  requester 0 mode: 0 = A+B, 1 = A−B.
- req1_valid, req1_ready, req1_a, req1_b, req1_mode  same meanings for requester 1.
- res_valid  out  1  result is available.
- res_ready  in  1  consumer accepts the result.
- res_s  out  WIDTH  sum or difference, modulo 2^WIDTH.
- res_cout  out  1  carry out; in subtract mode, 1 means no borrow (A ≥ B unsigned).
- res_ovf  out  1  two's-complement signed overflow.
- res_id  out  1  ID of the requester that owns the result.
- busy  out  1  state is not IDLE.

## Operation
- State machine: IDLE → EXEC → OUT → IDLE.
- IDLE:
  - If no valid is asserted, the block stays in IDLE.
  - If exactly one valid is asserted, that requester wins.
  - If both are asserted, the requester selected by the prio pointer wins.
  - The winner's ready is asserted combinationally in the same cycle. The loser's ready stays 0. Ready is never asserted without the matching valid.
  - On handshake: capture a, b, mode and the winner ID into operand registers, then go to EXEC.
- EXEC:
  - Compute S = A + (B XOR {WIDTH{mode}}) + mode, taking a (WIDTH+1)-bit result.
  - res_cout = bit WIDTH of that result.
  - Overflow in add mode: A[msb] == B[msb] and S[msb] != A[msb].
  - Overflow in subtract mode: A[msb] != B[msb] and S[msb] != A[msb].
  - Register res_s, res_cout, res_ovf and res_id, then go to OUT.
- OUT:
  - res_valid = 1. All res_* outputs hold stable until res_ready is sampled high.
  - On res_valid & res_ready, return to IDLE and set prio to the requester that was not just served.
- Round-robin: prio resets to 0 (requester 0 is preferred first). Prio is updated only on result completion, never on a cycle where nothing is granted. Continuous dual requests alternate 0,1,0,1,…
- Requester operands are sampled only at the handshake cycle. Changes after acceptance have no effect on the operation in flight.
- Requester valid is not required to stay high without ready. The block does not remember an un-granted request.
- Result outputs keep their last value after the completion handshake until the next EXEC overwrites them.

## Timing
- Reset, asynchronous with immediate effect:
  - state = IDLE, prio = 0.
  - res_valid = 0, res_s = 0, res_cout = 0, res_ovf = 0, res_id = 0.
  - busy = 0, req0_ready = req1_ready = 0.
- Reset mid-operation (in EXEC or OUT) drops the operation in flight. No result is produced for it.
- Latency: request accepted at cycle T → res_valid high from cycle T+2.
- Throughput: at best one operation per 3 cycles (accept, execute, result handshake at T+2). The next accept can happen at T+3.
- Back-pressure: each cycle res_ready is low in OUT adds one cycle. Both reqN_ready stay 0 throughout.
- A new request arriving in the same cycle as the result handshake is not accepted until the following IDLE cycle.
- busy = 1 in EXEC and OUT, 0 in IDLE.

## Test plan
- Reset values: assert rst mid-EXEC with req0 = 3+4 in flight → all outputs go to their reset values at once. After release, no res_valid appears for the dropped operation.
- Single add/subtract, res_ready tied high, each issued separately:
  - req0: A=0001, B=0010, mode 0 → res_s=0011, cout=0, ovf=0, id=0, at T+2.
  - req1: A=0101, B=0010, mode 1 → res_s=0011, cout=1, id=1.
- Wrap and borrow:
  - A=1111, B=0001, add → s=0000, cout=1, ovf=0.
  - A=0100, B=0110, subtract → s=1110, cout=0, ovf=0.
  - A=0111, B=0001, add → s=1000, ovf=1.
  - A=1000, B=0001, subtract → s=0111, ovf=1.
- Arbitration: both valid continuously for 4 operations from reset → grants 0,1,0,1, with res_id matching each grant. Only the winner's ready pulses, for one cycle per operation.
- Back-pressure: hold res_ready low for 5 cycles in OUT → res_* stable and both readies 0 throughout. Completion is on the first cycle res_ready goes high. The next accept follows one cycle later.
- Operand isolation: change req0_a/req0_b and the mode the cycle after acceptance → the result reflects only the captured values.
